// File: rtl/neuron_param_ram.sv
// Dual-port parameter store with registered read, write-first forwarding,
// out-of-range detection and a hardware clear sweep.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   wr_en/wr_addr/wr_data   write port
//   rd_en/rd_addr           read request (latency 1)
//   rd_data/rd_valid/rd_err registered read result
//   wr_err                  pulse: write dropped (out of range or busy)
//   clr_req                 start a full clear sweep
//   busy                    clear sweep in progress
module neuron_param_ram #(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 8,
  parameter int DEPTH          = 128,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_err,
  output logic              wr_err,
  input  logic              clr_req,
  output logic              busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit CHK   = (DEPTH < (2 ** ADDR_W));
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

  typedef enum logic {
    READY = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [IDX_W-1:0]  clr_addr;
  logic [IDX_W-1:0]  clr_addr_nxt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic             wr_in;
  logic             rd_in;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             is_ready;
  logic             wr_ok;
  logic             rd_ok;
  logic             collide;

  // Range check only exists when the address space exceeds the array.
  generate
    if (CHK) begin : g_chk
      localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);
      assign wr_in = ({1'b0, wr_addr} < DEPTH_V);
      assign rd_in = ({1'b0, rd_addr} < DEPTH_V);
    end else begin : g_full
      assign wr_in = 1'b1;
      assign rd_in = 1'b1;
    end
  endgenerate

  assign wr_idx   = wr_addr[IDX_W-1:0];
  assign rd_idx   = rd_addr[IDX_W-1:0];
  assign is_ready = (state == READY);
  assign busy     = (state == CLEAR);
  assign wr_ok    = rst_n & is_ready & wr_en & wr_in;
  assign rd_ok    = is_ready & rd_en;
  // Write-first: a same-cycle write to the read address wins.
  assign collide  = wr_ok & (wr_addr == rd_addr);

  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    unique case (state)
      READY: begin
        if (clr_req) begin
          state_nxt    = CLEAR;
          clr_addr_nxt = '0;
        end
      end
      CLEAR: begin
        if (clr_addr == LAST) begin
          state_nxt    = READY;
          clr_addr_nxt = '0;
        end else begin
          clr_addr_nxt = clr_addr + IDX_W'(1);
        end
      end
      default: begin
        state_nxt    = READY;
        clr_addr_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= CLEAR_ON_RESET ? CLEAR : READY;
      clr_addr <= '0;
    end else begin
      state    <= state_nxt;
      clr_addr <= clr_addr_nxt;
    end
  end

  // Array has no reset; the sweep zeroes it instead.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (busy) begin
        mem[clr_addr] <= '0;
      end else if (wr_ok) begin
        mem[wr_idx] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      wr_err   <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
      rd_err   <= rd_ok & ~rd_in;
      wr_err   <= wr_en & (busy | ~wr_in);
      if (rd_ok) begin
        if (!rd_in) begin
          rd_data <= '0;
        end else if (collide) begin
          rd_data <= wr_data;
        end else begin
          rd_data <= mem[rd_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_neuron_param_ram.sv
// Scoreboard bench for neuron_param_ram: directed scenarios plus random
// traffic against an array-and-counter reference model.
module tb_neuron_param_ram;

  localparam int DW    = 8;
  localparam int AW    = 8;
  localparam int DEPTH = 128;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          wr_en   = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en   = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          clr_req = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_err;
  logic          wr_err;
  logic          busy;

  neuron_param_ram #(
    .DATA_W(DW),
    .ADDR_W(AW),
    .DEPTH(DEPTH),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_en(rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .rd_err(rd_err),
    .wr_err(wr_err),
    .clr_req(clr_req),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          v;
    logic          e;
    logic          we;
    logic          b;
    logic [DW-1:0] d;
  } exp_t;

  exp_t q[$];
  int   tests_run = 0;
  int   failed    = 0;

  logic [DW-1:0] mdl_mem [DEPTH];
  int            busy_left = 0;
  logic [DW-1:0] mdl_data  = '0;

  task automatic chk(input string name, input int act, input int req);
    tests_run++;
    if (act != req) begin
      failed++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  task automatic zero_model();
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
  endtask

  // Drive one cycle of inputs and predict the outputs after the next edge.
  task automatic step(input logic r, input logic we, input int wa,
                      input logic [DW-1:0] wd, input logic re,
                      input int ra, input logic cr);
    exp_t x;
    @(negedge clk);
    rst_n   = r;
    wr_en   = we;
    wr_addr = AW'(wa);
    wr_data = wd;
    rd_en   = re;
    rd_addr = AW'(ra);
    clr_req = cr;
    x = '0;
    if (!r) begin
      busy_left = DEPTH;
      mdl_data  = '0;
      zero_model();
    end else if (busy_left > 0) begin
      x.we = we;
      busy_left--;
    end else begin
      x.we = we && (wa >= DEPTH);
      if (re) begin
        x.v = 1'b1;
        if (ra >= DEPTH) begin
          x.e      = 1'b1;
          mdl_data = '0;
        end else if (we && wa == ra) begin
          mdl_data = wd;
        end else begin
          mdl_data = mdl_mem[ra];
        end
      end
      if (we && wa < DEPTH) mdl_mem[wa] = wd;
      if (cr) begin
        busy_left = DEPTH;
        zero_model();
      end
    end
    x.b = (busy_left > 0);
    x.d = mdl_data;
    q.push_back(x);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 0, '0, 1'b0, 0, 1'b0);
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    step(1'b1, 1'b1, a, d, 1'b0, 0, 1'b0);
  endtask

  task automatic rd(input int a);
    step(1'b1, 1'b0, 0, '0, 1'b1, a, 1'b0);
  endtask

  // Monitor: one prediction per clock edge, sampled just after the edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("rd_valid", int'(rd_valid), int'(x.v));
        chk("wr_err", int'(wr_err), int'(x.we));
        chk("busy", int'(busy), int'(x.b));
        chk("rd_data", int'(rd_data), int'(x.d));
        if (x.v) chk("rd_err", int'(rd_err), int'(x.e));
      end
    end
  end

  initial begin
    int wa;
    int ra;
    // T1: reset, full sweep, all zero
    step(1'b0, 1'b0, 0, '0, 1'b0, 0, 1'b0);
    step(1'b0, 1'b0, 0, '0, 1'b0, 0, 1'b0);
    repeat (DEPTH) idle();
    idle();
    for (int i = 0; i < DEPTH; i++) rd(i);
    idle();
    // T2: write then back-to-back reads
    wr(0, 8'h0A);
    wr(2, 8'h0B);
    wr(7, 8'h03);
    rd(7);
    rd(2);
    rd(0);
    idle();
    // T3: collision write-first
    wr(5, 8'h11);
    step(1'b1, 1'b1, 5, 8'h22, 1'b1, 5, 1'b0);
    rd(5);
    // T4: out-of-range
    wr(200, 8'hFF);
    rd(200);
    rd(72);
    idle();
    // T5: fill, clear request with same-cycle ops, ops while busy
    for (int i = 0; i < DEPTH; i++) wr(i, DW'($urandom));
    rd(17);
    step(1'b1, 1'b1, 9, 8'h5A, 1'b1, 9, 1'b1);
    rd(3);
    wr(4, 8'h44);
    step(1'b1, 1'b1, 6, 8'h66, 1'b1, 6, 1'b1);
    repeat (DEPTH) idle();
    for (int i = 0; i < DEPTH; i++) rd(i);
    // T6: reset mid-sweep
    step(1'b1, 1'b0, 0, '0, 1'b0, 0, 1'b1);
    repeat (60) idle();
    step(1'b0, 1'b0, 0, '0, 1'b0, 0, 1'b0);
    repeat (DEPTH + 2) idle();
    rd(0);
    rd(127);
    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      wa = ($urandom_range(0, 9) == 0) ? int'($urandom_range(128, 255))
                                       : int'($urandom_range(0, 15));
      ra = ($urandom_range(0, 2) == 0) ? wa
                                       : int'($urandom_range(0, 20));
      if ($urandom_range(0, 15) == 0) ra = int'($urandom_range(0, 255));
      step(($urandom_range(0, 599) != 0),
           1'($urandom),
           wa,
           DW'($urandom),
           1'($urandom),
           ra,
           ($urandom_range(0, 299) == 0));
    end
    idle();
    idle();
    repeat (2) @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
